// File: rtl/debug_blink_scheduler.sv
// debug_blink_scheduler
//   Shares one debug status LED between NUM_SRC requesters. Each requester
//   asks for a numeric blink code; the granted code is shown as N LED pulses
//   followed by a dark gap. Timing is derived from the rising edges of the
//   1 kHz debug square wave. Requesters are served round-robin.
//
// Ports
//   clk_in      system clock (same domain as clock_1khz)
//   resetn_i    asynchronous active-low reset
//   clock_1khz  1 kHz square wave; each rising edge is one tick
//   req_i       per-source level request
//   code_i      per-source blink code, source k = code_i[k*CODE_W +: CODE_W]
//   ack_o       one-cycle grant pulse, cycle after the grant decision
//   led_o       LED drive, 1 = on (registered, high exactly while in ON)
//   busy_o      high while a code is in progress
//   cur_src_o   index of the last granted source
module debug_blink_scheduler #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned CODE_W    = 4,
  parameter int unsigned ON_TICKS  = 250,
  parameter int unsigned OFF_TICKS = 250,
  parameter int unsigned GAP_TICKS = 1500,
  parameter int unsigned CNT_W     = 12,
  localparam int unsigned SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        clk_in,
  input  logic                        resetn_i,
  input  logic                        clock_1khz,
  input  logic [NUM_SRC-1:0]          req_i,
  input  logic [NUM_SRC*CODE_W-1:0]   code_i,
  output logic [NUM_SRC-1:0]          ack_o,
  output logic                        led_o,
  output logic                        busy_o,
  output logic [SRC_W-1:0]            cur_src_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [CODE_W-1:0]   blink_cnt, blink_n;
  logic [SRC_W-1:0]    rr_ptr, rr_n;
  logic [SRC_W-1:0]    cur_n;
  logic [NUM_SRC-1:0]  ack_n;
  logic                entry, entry_n;
  logic                clock_1khz_q;
  logic                tick;
  logic                tick_use;

  logic                grant_vld;
  logic [SRC_W-1:0]    grant_idx;
  logic [SRC_W-1:0]    rr_next;
  logic [CODE_W-1:0]   grant_code;
  logic [31:0]         scan_idx;

  // One tick per rising edge of the 1 kHz wave; a stuck-high input gives one tick.
  assign tick = clock_1khz & ~clock_1khz_q;

  // The first cycle after a state entry ignores ticks, so every phase
  // counts exactly its programmed number of full ticks.
  assign tick_use = tick & ~entry;

  // Round-robin search starting at rr_ptr, first requesting source wins.
  always_comb begin : rr_search
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      scan_idx = (32'(rr_ptr) + i) % NUM_SRC;
      if (!grant_vld && req_i[SRC_W'(scan_idx)]) begin
        grant_vld = 1'b1;
        grant_idx = SRC_W'(scan_idx);
      end
    end
  end

  assign rr_next    = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
  assign grant_code = code_i[32'(grant_idx) * CODE_W +: CODE_W];

  // Next-state and next-register values for the blink sequencer.
  always_comb begin : fsm_next
    state_n = state;
    cnt_n   = cnt;
    blink_n = blink_cnt;
    rr_n    = rr_ptr;
    cur_n   = cur_src_o;
    ack_n   = '0;
    entry_n = 1'b0;

    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          blink_n = grant_code;
          cur_n   = grant_idx;
          rr_n    = rr_next;
          ack_n   = NUM_SRC'(1) << grant_idx;
          // A zero code is acknowledged but shows nothing.
          if (grant_code != '0) begin
            state_n = ST_ON;
            cnt_n   = '0;
            entry_n = 1'b1;
          end
        end
      end

      ST_ON: begin
        if (tick_use) begin
          if (cnt == CNT_W'(ON_TICKS - 1)) begin
            state_n = ST_OFF;
            cnt_n   = '0;
            entry_n = 1'b1;
            blink_n = blink_cnt - CODE_W'(1);
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end

      ST_OFF: begin
        if (tick_use) begin
          if (cnt == CNT_W'(OFF_TICKS - 1)) begin
            state_n = (blink_cnt == '0) ? ST_GAP : ST_ON;
            cnt_n   = '0;
            entry_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (tick_use) begin
          if (cnt == CNT_W'(GAP_TICKS - 1)) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            entry_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; LED/busy decode from next state
  // so they change in the same cycle as the state register.
  always_ff @(posedge clk_in or negedge resetn_i) begin : fsm_regs
    if (!resetn_i) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      blink_cnt    <= '0;
      rr_ptr       <= '0;
      entry        <= 1'b0;
      clock_1khz_q <= 1'b0;
      ack_o        <= '0;
      led_o        <= 1'b0;
      busy_o       <= 1'b0;
      cur_src_o    <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      blink_cnt    <= blink_n;
      rr_ptr       <= rr_n;
      entry        <= entry_n;
      clock_1khz_q <= clock_1khz;
      ack_o        <= ack_n;
      led_o        <= (state_n == ST_ON);
      busy_o       <= (state_n != ST_IDLE);
      cur_src_o    <= cur_n;
    end
  end

endmodule

// File: tb/tb_debug_blink_scheduler.sv
// tb_debug_blink_scheduler
//   Bench for debug_blink_scheduler with short tick counts (ON=2, OFF=2, GAP=4)
//   and a 1 kHz stand-in that rises every 10 clocks.
module tb_debug_blink_scheduler;

  localparam int unsigned NS   = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned ONT  = 2;
  localparam int unsigned OFFT = 2;
  localparam int unsigned GAPT = 4;

  localparam int M_HOLD  = 0;
  localparam int M_DROP  = 1;
  localparam int M_PULSE = 2;

  logic             clk    = 1'b0;
  logic             resetn = 1'b0;
  logic             clk1k  = 1'b0;
  logic [NS-1:0]    req    = '0;
  logic [NS*CW-1:0] code   = '0;
  logic [NS-1:0]    ack;
  logic             led;
  logic             busy;
  logic [1:0]       cur_src;

  debug_blink_scheduler #(
    .NUM_SRC  (NS),
    .CODE_W   (CW),
    .ON_TICKS (ONT),
    .OFF_TICKS(OFFT),
    .GAP_TICKS(GAPT),
    .CNT_W    (12)
  ) dut (
    .clk_in    (clk),
    .resetn_i  (resetn),
    .clock_1khz(clk1k),
    .req_i     (req),
    .code_i    (code),
    .ack_o     (ack),
    .led_o     (led),
    .busy_o    (busy),
    .cur_src_o (cur_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0]    req;
    logic [NS*CW-1:0] code;
    int               mode;
    logic [NS-1:0]    ack;
    logic [1:0]       src;
    int               blinks;
  } vec_t;

  typedef struct {
    logic [NS-1:0] ack;
    logic [1:0]    src;
    int            blinks;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  int n_vec    = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;
  bit stuck    = 1'b0;
  bit tick_b   = 1'b0;
  int ph       = 0;

  // Monitor state
  bit            in_txn   = 1'b0;
  bit            prev1k   = 1'b0;
  bit            led_prev = 1'b0;
  bit            on_ok    = 1'b1;
  logic [NS-1:0] a_v;
  logic [1:0]    s_v;
  int            blinks_v = 0;
  int            total_v  = 0;
  int            cur_on   = 0;

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, want);
    end
  endtask

  // 1 kHz stand-in: toggles every 5 clocks, or held high while stuck is set.
  initial begin : gen_1khz
    forever begin
      @(posedge clk); #1;
      if (stuck) begin
        clk1k = 1'b1;
        ph    = 0;
      end else begin
        ph++;
        if (ph >= 5) begin
          ph    = 0;
          clk1k = ~clk1k;
        end
      end
    end
  end

  task automatic finish_txn(input logic [NS-1:0] a, input logic [1:0] s,
                            input int b, input int t, input bit ok);
    exp_t e;
    int   want_t;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL unexpected_grant: actual ack %b required none", a);
    end else begin
      e      = sb.pop_front();
      want_t = (e.blinks == 0) ? 0 : e.blinks * int'(ONT + OFFT) + int'(GAPT);
      chk("ack", int'(a), int'(e.ack));
      chk("cur_src", int'(s), int'(e.src));
      chk("blink_count", b, e.blinks);
      chk("code_ticks", t, want_t);
      chk("on_width", int'(ok), 1);
    end
    done_cnt++;
  endtask

  // Observes each grant and the LED activity that follows it, counting ticks
  // with the same rising-edge rule; the first cycle of each LED pulse is the
  // state-entry cycle and its tick is not counted.
  initial begin : monitor
    forever begin
      @(negedge clk);
      tick_b = clk1k & ~prev1k;
      prev1k = clk1k;
      if (!mon_en || !resetn) begin
        in_txn = 1'b0;
      end else if (!in_txn) begin
        if (ack != '0) begin
          a_v      = ack;
          s_v      = cur_src;
          blinks_v = led ? 1 : 0;
          total_v  = 0;
          cur_on   = 0;
          on_ok    = 1'b1;
          led_prev = led;
          if (busy) in_txn = 1'b1;
          else finish_txn(a_v, s_v, blinks_v, total_v, on_ok);
        end
      end else begin
        if (!busy) begin
          in_txn = 1'b0;
          finish_txn(a_v, s_v, blinks_v, total_v, on_ok);
        end else begin
          if (led && !led_prev) begin
            blinks_v++;
            cur_on = 0;
          end else begin
            if (!led && led_prev && cur_on != int'(ONT)) on_ok = 1'b0;
            if (tick_b) begin
              total_v++;
              if (led) cur_on++;
            end
          end
          led_prev = led;
        end
      end
    end
  end

  task automatic wait_done(input int target);
    int c;
    c = 0;
    while (done_cnt < target && c < 3000) begin
      @(negedge clk); #1;
      c++;
    end
    if (done_cnt < target) begin
      n_vec++;
      n_fail++;
      $display("FAIL completion_timeout: actual %0d completions required %0d", done_cnt, target);
      sb.delete();
      done_cnt = target;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int target;
    int c;
    target = done_cnt + 1;
    req    = v.req;
    code   = v.code;
    sb.push_back('{ack: v.ack, src: v.src, blinks: v.blinks});
    if (v.mode == M_PULSE) begin
      @(negedge clk); #1;
      req = '0;
    end else if (v.mode == M_DROP) begin
      c = 0;
      while (ack == '0 && c < 200) begin
        @(negedge clk); #1;
        c++;
      end
      req = '0;
    end
    wait_done(target);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  c;
    int  target;
    bit  held_ok;

    //            req      code      mode     ack      src  blinks
    vecs[0] = '{4'b0010, 16'h0030, M_DROP,  4'b0010, 2'd1, 3};
    vecs[1] = '{4'b1000, 16'h0000, M_PULSE, 4'b1000, 2'd3, 0};
    vecs[2] = '{4'b0101, 16'h0201, M_HOLD,  4'b0001, 2'd0, 1};
    vecs[3] = '{4'b0101, 16'h0201, M_HOLD,  4'b0100, 2'd2, 2};
    vecs[4] = '{4'b0101, 16'h0201, M_HOLD,  4'b0001, 2'd0, 1};
    vecs[5] = '{4'b0101, 16'h0201, M_HOLD,  4'b0100, 2'd2, 2};

    // Reset held while the 1 kHz wave toggles
    repeat (25) @(negedge clk);
    #1;
    chk("reset_led", int'(led), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ack", int'(ack), 0);
    chk("reset_cur_src", int'(cur_src), 0);
    resetn = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Single code, zero code, then round robin from index 0
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    req = '0;

    // Stuck-high 1 kHz during ON: one tick only, LED holds until next rise
    target = done_cnt + 1;
    req    = 4'b0001;
    code   = 16'h0001;
    sb.push_back('{ack: 4'b0001, src: 2'd0, blinks: 1});
    @(negedge clk); #1;
    req = '0;
    c = 0;
    while (!led && c < 100) begin
      @(negedge clk); #1;
      c++;
    end
    c = 0;
    @(negedge clk); #1;
    while (!tick_b && c < 100) begin
      @(negedge clk); #1;
      c++;
    end
    stuck   = 1'b1;
    held_ok = 1'b1;
    repeat (50) begin
      @(negedge clk); #1;
      if (!led) held_ok = 1'b0;
    end
    chk("stuck_led_held", int'(held_ok), 1);
    stuck = 1'b0;
    c = 0;
    while (led && c < 40) begin
      @(negedge clk); #1;
      c++;
    end
    chk("stuck_led_fall", int'(led), 0);
    wait_done(target);

    // Reset in the middle of a code-5 ON phase
    mon_en = 1'b0;
    req    = 4'b0100;
    code   = 16'h0500;
    @(negedge clk); #1;
    req = '0;
    c = 0;
    while (ack == '0 && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    chk("code5_ack", int'(ack), 4'b0100);
    chk("code5_cur_src", int'(cur_src), 2);
    repeat (3) @(negedge clk);
    #1;
    chk("code5_led_on", int'(led), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrun_reset_led", int'(led), 0);
    chk("midrun_reset_busy", int'(busy), 0);
    chk("midrun_reset_ack", int'(ack), 0);
    chk("midrun_reset_cur_src", int'(cur_src), 0);
    repeat (3) @(negedge clk);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk); #1;

    // After reset the search restarts at index 0: source 2 beats source 3
    run_vec('{4'b1100, 16'h2100, M_PULSE, 4'b0100, 2'd2, 1});

    repeat (20) @(negedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    chk("idle_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
